// File: rtl/link_sync_pkg.sv
// Constants shared by the lane framer (tx) and the lane aligner (rx):
// sync pattern, aligner lock thresholds and the tx framer state encoding.
package link_sync_pkg;

    localparam logic [15:0] SYNC_PATTERN = 16'h817E;
    localparam logic [5:0]  LOCK_LEVEL   = 6'h10;
    localparam logic [5:0]  UNLOCK_LEVEL = 6'h08;

    typedef enum logic [1:0] {
        TX_IDLE     = 2'b00,
        TX_PREAMBLE = 2'b01,
        TX_DATA     = 2'b10,
        TX_RESYNC   = 2'b11
    } tx_state_t;

    function automatic logic is_sync_word(input logic [15:0] word);
        return (word == SYNC_PATTERN);
    endfunction

endpackage

// File: rtl/sync_insert_tx_if.sv
// Upstream valid/ready word channel plus the registered line-side outputs
// of one framed 16-bit lane.
interface sync_insert_tx_if;
    logic        valid_in;
    logic [15:0] datain;
    logic        ready;
    logic        valid;
    logic [15:0] dataout;
    logic        sync_active;
    logic        collision;

    modport master (
        output valid_in, datain,
        input  ready, valid, dataout, sync_active, collision
    );

    modport slave (
        input  valid_in, datain,
        output ready, valid, dataout, sync_active, collision
    );
endinterface

// File: rtl/sync_insert_tx.sv
// Transmit framer for one lane: sync preamble after enable/resync, then
// handshaked data forwarding with periodic sync bursts to hold rx lock.
module sync_insert_tx
    import link_sync_pkg::*;
#(
    parameter int SYNC_PREAMBLE = 20,
    parameter int SYNC_BURST    = 2,
    parameter int SYNC_PERIOD   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             resync_req,
    sync_insert_tx_if.slave  lnk
);

    localparam logic [7:0]  PRE_LAST   = 8'(SYNC_PREAMBLE - 1);
    localparam logic [7:0]  BURST_LAST = 8'(SYNC_BURST - 1);
    localparam logic [15:0] PERIOD_LEN = 16'(SYNC_PERIOD);
    localparam bit          PERIOD_EN  = (SYNC_PERIOD != 0);

    tx_state_t   state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [15:0] period_cnt_r, period_nxt_s;
    logic        pend_r, pend_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic [15:0] dataout_r, dataout_nxt_s;
    logic        sync_r, sync_nxt_s;
    logic        coll_r, coll_nxt_s;
    logic        period_hit_s;
    logic        ready_s;
    logic        transfer_s;

    assign period_hit_s = PERIOD_EN && (period_cnt_r == PERIOD_LEN);
    assign ready_s      = (state_r == TX_DATA) && enable && !pend_r && !period_hit_s;
    assign transfer_s   = lnk.valid_in && ready_s;

    assign lnk.ready       = ready_s;
    assign lnk.valid       = valid_r;
    assign lnk.dataout     = dataout_r;
    assign lnk.sync_active = sync_r;
    assign lnk.collision   = coll_r;

    // Next-state, counter and line-word selection; enable=0 overrides all.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        period_nxt_s  = period_cnt_r;
        valid_nxt_s   = 1'b0;
        dataout_nxt_s = dataout_r;
        sync_nxt_s    = 1'b0;
        coll_nxt_s    = 1'b0;
        if ((state_r != TX_IDLE) && resync_req) begin
            pend_nxt_s = 1'b1;
        end else begin
            pend_nxt_s = pend_r;
        end

        if (!enable) begin
            state_nxt_s  = TX_IDLE;
            cnt_nxt_s    = 8'd0;
            period_nxt_s = 16'd0;
            pend_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    state_nxt_s  = TX_PREAMBLE;
                    cnt_nxt_s    = 8'd0;
                    period_nxt_s = 16'd0;
                    pend_nxt_s   = 1'b0;
                end
                TX_PREAMBLE: begin
                    valid_nxt_s   = 1'b1;
                    dataout_nxt_s = SYNC_PATTERN;
                    sync_nxt_s    = 1'b1;
                    period_nxt_s  = 16'd0;
                    pend_nxt_s    = 1'b0;
                    // A fresh request restarts the full preamble length.
                    if (resync_req) begin
                        cnt_nxt_s = 8'd0;
                    end else if (cnt_r == PRE_LAST) begin
                        cnt_nxt_s   = 8'd0;
                        state_nxt_s = TX_DATA;
                    end else begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end
                TX_DATA: begin
                    if (pend_r) begin
                        state_nxt_s = TX_PREAMBLE;
                        cnt_nxt_s   = 8'd0;
                        pend_nxt_s  = 1'b0;
                    end else if (period_hit_s) begin
                        state_nxt_s = TX_RESYNC;
                        cnt_nxt_s   = 8'd0;
                    end else if (transfer_s) begin
                        valid_nxt_s   = 1'b1;
                        dataout_nxt_s = lnk.datain;
                        coll_nxt_s    = is_sync_word(lnk.datain);
                        period_nxt_s  = period_cnt_r + 16'd1;
                    end else begin
                        valid_nxt_s = 1'b0;
                    end
                end
                TX_RESYNC: begin
                    valid_nxt_s   = 1'b1;
                    dataout_nxt_s = SYNC_PATTERN;
                    sync_nxt_s    = 1'b1;
                    if (cnt_r == BURST_LAST) begin
                        cnt_nxt_s    = 8'd0;
                        period_nxt_s = 16'd0;
                        // A request seen during the burst becomes a full preamble.
                        if (pend_r || resync_req) begin
                            state_nxt_s = TX_PREAMBLE;
                            pend_nxt_s  = 1'b0;
                        end else begin
                            state_nxt_s = TX_DATA;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_nxt_s  = TX_IDLE;
                    cnt_nxt_s    = 8'd0;
                    period_nxt_s = 16'd0;
                    pend_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= TX_IDLE;
            cnt_r        <= 8'd0;
            period_cnt_r <= 16'd0;
            pend_r       <= 1'b0;
            valid_r      <= 1'b0;
            dataout_r    <= 16'h0000;
            sync_r       <= 1'b0;
            coll_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            period_cnt_r <= period_nxt_s;
            pend_r       <= pend_nxt_s;
            valid_r      <= valid_nxt_s;
            dataout_r    <= dataout_nxt_s;
            sync_r       <= sync_nxt_s;
            coll_r       <= coll_nxt_s;
        end
    end

endmodule

// File: tb/tb_sync_insert_tx.sv
// Self-checking bench for sync_insert_tx: cycle vector table for reset/preamble
// timing, then line-word streams compared against a stream-level model.
module tb_sync_insert_tx;
    import link_sync_pkg::*;

    localparam int PRE    = 20;
    localparam int BURST  = 2;
    localparam int PERIOD = 8;
    localparam logic [17:0] SYNC_ENT = {1'b1, 1'b0, 16'h817E};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic resync_req = 1'b0;

    sync_insert_tx_if lnk();

    sync_insert_tx #(
        .SYNC_PREAMBLE(PRE),
        .SYNC_BURST(BURST),
        .SYNC_PERIOD(PERIOD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .resync_req(resync_req),
        .lnk(lnk)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {sync_active, collision, dataout}
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    logic [15:0] tx_q[$];
    logic [15:0] acc_q[$];

    typedef struct {
        logic        en;
        logic        req;
        logic        vin;
        logic [15:0] din;
        logic        rdy;
        logic        vld;
        logic [15:0] dout;
        logic        sa;
        logic        col;
    } vec_t;

    vec_t tbl[27];

    always @(negedge clk) begin
        if (!rst && lnk.valid) got_q.push_back({lnk.sync_active, lnk.collision, lnk.dataout});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic restart();
        @(posedge clk); #1;
        enable = 1'b0;
        lnk.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        acc_q.delete();
        enable = 1'b1;
    endtask

    // Feeds tx_q through the handshake; optionally pulses resync_req in the
    // cycle that req_word is accepted.
    task automatic drive_stream(input int gap_pct, input logic do_req, input logic [15:0] req_word);
        int cyc = 0;
        int tail = 0;
        while (tail < 12) begin
            @(posedge clk); #1;
            resync_req = 1'b0;
            lnk.valid_in = (tx_q.size() > 0) && ($urandom_range(99) >= gap_pct);
            lnk.datain = lnk.valid_in ? tx_q[0] : 16'h0000;
            #1;
            if (lnk.valid_in && lnk.ready) begin
                acc_q.push_back(tx_q.pop_front());
                if (do_req && acc_q[$] == req_word) resync_req = 1'b1;
            end
            if (tx_q.size() == 0) tail++;
            cyc++;
            if (cyc > 3000) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_timeout: got %0d words left expected 0", tx_q.size());
                tx_q.delete();
                break;
            end
        end
    endtask

    // Line stream: preamble, each accepted word, a burst after every PERIOD words.
    task automatic model_build();
        int cnt = 0;
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(SYNC_ENT);
        foreach (acc_q[i]) begin
            exp_q.push_back({1'b0, acc_q[i] == 16'h817E, acc_q[i]});
            cnt++;
            if (cnt == PERIOD) begin
                for (int j = 0; j < BURST; j++) exp_q.push_back(SYNC_ENT);
                cnt = 0;
            end
        end
    endtask

    task automatic check_stream(input string name);
        int n;
        check({name, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", name, i), {14'd0, got_q[i]}, {14'd0, exp_q[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        lnk.valid_in = 1'b0;
        lnk.datain = 16'h0000;

        // Cycle table starting right after reset release.
        for (int i = 0; i < 27; i++) begin
            tbl[i] = '{en: 1'b1, req: 1'b0, vin: 1'b0, din: 16'h0000, rdy: 1'b0,
                       vld: 1'b0, dout: 16'h0000, sa: 1'b0, col: 1'b0};
        end
        for (int i = 2; i <= 21; i++) begin
            tbl[i].vld = 1'b1;
            tbl[i].dout = 16'h817E;
            tbl[i].sa = 1'b1;
        end
        tbl[21].rdy = 1'b1; tbl[21].vin = 1'b1; tbl[21].din = 16'h0001;
        tbl[22] = '{en: 1'b1, req: 1'b0, vin: 1'b1, din: 16'h817E, rdy: 1'b1,
                    vld: 1'b1, dout: 16'h0001, sa: 1'b0, col: 1'b0};
        tbl[23] = '{en: 1'b1, req: 1'b0, vin: 1'b0, din: 16'h0000, rdy: 1'b1,
                    vld: 1'b1, dout: 16'h817E, sa: 1'b0, col: 1'b1};
        tbl[24] = '{en: 1'b1, req: 1'b0, vin: 1'b0, din: 16'h0000, rdy: 1'b1,
                    vld: 1'b0, dout: 16'h817E, sa: 1'b0, col: 1'b0};
        tbl[25] = '{en: 1'b0, req: 1'b0, vin: 1'b1, din: 16'h00AA, rdy: 1'b0,
                    vld: 1'b0, dout: 16'h817E, sa: 1'b0, col: 1'b0};
        tbl[26] = tbl[25];

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {11'd0, lnk.ready, lnk.valid, lnk.dataout, lnk.sync_active, lnk.collision},
              32'd0);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            @(posedge clk); #1;
            enable = tbl[i].en;
            resync_req = tbl[i].req;
            lnk.valid_in = tbl[i].vin;
            lnk.datain = tbl[i].din;
            #1;
            check($sformatf("vec%0d", i),
                  {11'd0, lnk.ready, lnk.valid, lnk.dataout, lnk.sync_active, lnk.collision},
                  {11'd0, tbl[i].rdy, tbl[i].vld, tbl[i].dout, tbl[i].sa, tbl[i].col});
        end

        // Re-enable with 0x00AA still pending: full preamble, then 0x00AA.
        got_q.delete();
        acc_q.delete();
        tx_q.delete();
        tx_q.push_back(16'h00AA);
        enable = 1'b1;
        drive_stream(0, 1'b0, 16'h0000);
        model_build();
        check_stream("reenable");

        // Periodic bursts every PERIOD accepted words.
        restart();
        for (int w = 1; w <= 16; w++) tx_q.push_back(16'(w));
        drive_stream(0, 1'b0, 16'h0000);
        model_build();
        check_stream("period");

        // resync_req in the cycle word 3 is accepted.
        restart();
        for (int w = 1; w <= 6; w++) tx_q.push_back(16'(w));
        drive_stream(0, 1'b1, 16'h0003);
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(SYNC_ENT);
        for (int w = 1; w <= 3; w++) exp_q.push_back({2'b00, 16'(w)});
        for (int i = 0; i < PRE; i++) exp_q.push_back(SYNC_ENT);
        for (int w = 4; w <= 6; w++) exp_q.push_back({2'b00, 16'(w)});
        check_stream("resync");

        // Randomized traffic with gaps and occasional sync-valued data.
        restart();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(15) == 0) tx_q.push_back(16'h817E);
            else tx_q.push_back(16'($urandom()));
        end
        drive_stream(30, 1'b0, 16'h0000);
        model_build();
        check_stream("random");

        // Reset asserted mid-stream aborts to reset values.
        tx_q.push_back(16'h1234);
        @(posedge clk); #1;
        lnk.valid_in = 1'b1;
        lnk.datain = 16'h1234;
        rst = 1'b1;
        #1;
        check("midreset_outputs", {11'd0, lnk.ready, lnk.valid, lnk.dataout, lnk.sync_active, lnk.collision},
              32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        lnk.valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_insert_tx.md
Name: sync_insert_tx

Overview:
Transmit-side framer for one 16-bit lane of the deserialized link; it feeds the receive-side lane aligner. After enable it emits a preamble of sync words (16'h817E), long enough for the far-end aligner to lock. It then forwards user data through a valid/ready handshake and periodically re-inserts short sync bursts so the receiver keeps its lock.

Parameters:
SYNC_PREAMBLE, 20, number of sync words sent after enable or resync_req (must exceed receiver lock level 16); range 1..255
SYNC_BURST, 2, sync words per periodic resync burst; range 1..255
SYNC_PERIOD, 1024, accepted data words between periodic bursts; 0 disables periodic bursts; range 0..65535

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
enable  input  1  level; 1 = transmitter active
resync_req  input  1  single-cycle pulse; request a full preamble
valid_in  input  1  upstream word valid
datain  input  16  upstream data word
ready  output  1  upstream may transfer this cycle (combinational)
valid  output  1  registered; dataout is a sync or data word
dataout  output  16  registered line word
sync_active  output  1  registered; 1 while dataout carries a sync word
collision  output  1  registered one-cycle pulse; forwarded data word equals the sync pattern

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Reset: state=IDLE; valid=0, dataout=16'h0000, sync_active=0, collision=0; all counters 0; ready=0.
- States: IDLE, PREAMBLE, DATA, RESYNC (2-bit encoding from the package).
- IDLE:
  - valid=0 and dataout holds its value.
  - enable=1 moves to PREAMBLE at the next edge, with the preamble counter cleared.
- PREAMBLE:
  - Every cycle registers dataout=16'h817E, valid=1, sync_active=1.
  - Count reaching SYNC_PREAMBLE moves to DATA, so exactly SYNC_PREAMBLE consecutive sync words are sent.
  - The period counter is cleared.
- DATA:
  - ready = (state==DATA) && enable && !resync_pend && !period_hit.
  - Transfer = valid_in && ready. On a transfer, the next edge registers valid=1, dataout=datain, sync_active=0, so latency is 1 cycle.
  - No transfer: valid=0 and dataout holds its value.
  - collision=1 on the edge that registers a forwarded word equal to 16'h817E; the word is still forwarded unchanged.
- Period counter (16-bit):
  - Increments on each transfer.
  - When it reaches SYNC_PERIOD (and SYNC_PERIOD≠0), period_hit=1, ready drops and the next edge enters RESYNC.
- RESYNC:
  - Emits SYNC_BURST sync words with valid=1, sync_active=1.
  - Then clears the period counter and returns to DATA.
- resync_req:
  - Captured into resync_pend in any state other than IDLE.
  - In DATA, a set resync_pend forces ready=0 and moves to PREAMBLE at the next edge; pend clears on PREAMBLE entry.
  - A request during PREAMBLE restarts the preamble count from 0.
  - A request during RESYNC is serviced as a full PREAMBLE after the burst ends.
  - Ignored in IDLE.
- enable=0 in any state:
  - Next edge goes to IDLE with valid=0.
  - ready is low in that same cycle, so no word is accepted and none is lost.
  - All counters and resync_pend clear.
- Priority on the same edge: enable=0 > resync_pend > period_hit > normal transfer.
- Reset mid-stream aborts immediately to reset values. On the next enable a full preamble is sent.

Decomposition:
- Shared package (link_sync_pkg):
  - SYNC_PATTERN = 16'h817E
  - LOCK_LEVEL = 6'h10 and UNLOCK_LEVEL = 6'h08 (the receiver's constants move here too)
  - tx state encoding constants
- Single module with all counters inline. No sub-module is warranted; the 16-lane receiver remains the consumer.

Test Plan:
- Reset, then enable=1 with SYNC_PREAMBLE=20 -> exactly 20 cycles of valid=1, dataout=16'h817E, sync_active=1, then ready=1.
- Stream 16'h0001..16'h0010 with valid_in held high, SYNC_PERIOD=8, SYNC_BURST=2 -> output 0001..0008, 2×817E, 0009..0010, 2×817E. Each data word appears 1 cycle after its transfer, with no drops or duplicates.
- resync_req pulsed mid-stream after word 0x0003 is transferred -> word 0003 is output, then ready=0 and 20 sync words are sent, then 0004 resumes.
- enable dropped while valid_in=1 with data 0x00AA -> ready=0 that cycle, valid=0 next cycle, 0x00AA is not consumed. Re-enable -> full preamble, then 0x00AA is sent.
- Forward data 16'h817E -> dataout=817E with sync_active=0 and a single collision pulse.
- Back-to-back: connect 16 instances to the receive aligner with lane 5 enabled first -> the aligner locks lane 5 and passes subsequent data bit-exact.
